// File: rtl/ahb_lite_sram_slave_v2.sv
// Byte-addressed AHB-Lite SRAM slave with per-type wait states, range/alignment/size
// checks, SEQ-address tracking (incl. WRAP4/8/16) and the two-cycle ERROR response.
module ahb_lite_sram_slave_v2 #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_BYTES = 1024,
  parameter int LW_NS     = 0,
  parameter int LW_S      = 0,
  parameter int LR_NS     = 1,
  parameter int LR_S      = 0,
  parameter int CHECK_SEQ = 1
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [DW-1:0] hwdata,
  input  logic          error,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic          hresp,
  output logic          busy_o
);

  localparam int NB  = DW / 8;
  localparam int NBL = $clog2(NB);
  localparam int MAW = $clog2(MEM_BYTES);

  // Handshake: a transfer's address phase is taken on the rising edge where
  // hready & hsel & htrans[1]; its data phase ends on the edge where hready=1 again.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     cnt, cnt_nxt;
  logic [AW-1:0]  exp_addr;
  logic [MAW-1:0] d_addr;
  logic           d_write;
  logic [2:0]     d_size;
  logic [7:0]     mem [MEM_BYTES];

  logic           accept, bad, is_seq;
  logic [7:0]     lat;
  logic [4:0]     beats;
  logic [AW-1:0]  size_bytes, incr, bound, exp_nxt;
  logic [NB-1:0]  lane_en;
  logic [MAW-1:0] base;

  assign hready = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign hresp  = (state == S_ERR1) || (state == S_ERR2);
  assign busy_o = (state == S_WAIT) || (state == S_ERR1) || (state == S_ERR2);

  assign accept     = hready && hsel && htrans[1];
  assign is_seq     = (htrans == 2'b11);
  assign size_bytes = AW'(1) << hsize;

  assign bad = (haddr >= AW'(MEM_BYTES))
            || ((haddr & (size_bytes - AW'(1))) != '0)
            || (hsize > 3'(NBL))
            || error
            || ((CHECK_SEQ != 0) && is_seq && (haddr != exp_addr));

  always_comb begin
    if (hwrite) lat = is_seq ? 8'(LW_S) : 8'(LW_NS);
    else        lat = is_seq ? 8'(LR_S) : 8'(LR_NS);
  end

  always_comb begin
    case (hburst)
      3'd2:    beats = 5'd4;
      3'd4:    beats = 5'd8;
      3'd6:    beats = 5'd16;
      default: beats = 5'd0;
    endcase
  end

  // Wrapping bursts keep the upper address bits and wrap the low ones inside the boundary.
  assign incr    = haddr + size_bytes;
  assign bound   = AW'(beats) << hsize;
  assign exp_nxt = (beats == 5'd0) ? incr
                 : ((haddr & ~(bound - AW'(1))) | (incr & (bound - AW'(1))));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) state_nxt = S_DONE;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (lat != 8'd0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = lat;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      exp_addr <= '0;
      d_addr   <= '0;
      d_write  <= 1'b0;
      d_size   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        d_addr  <= haddr[MAW-1:0];
        d_write <= hwrite;
        d_size  <= hsize;
        if (!bad) exp_addr <= exp_nxt;
      end
    end
  end

  assign base = d_addr & ~MAW'(NB - 1);

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lane_en[i] = (i >= int'(d_addr[NBL-1:0]))
                && (i < int'(d_addr[NBL-1:0]) + (1 << d_size));
    end
  end

  // Memory is deliberately left out of reset; only the DONE cycle of a good write touches it.
  always_ff @(posedge hclk) begin
    if (state == S_DONE && d_write) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[base | MAW'(i)] <= hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (state == S_DONE && !d_write) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) hrdata[8*i +: 8] = mem[base | MAW'(i)];
      end
    end
  end

endmodule
